// File: rtl/gate_sequencer_if.sv
// Bus between the gate sequencer, the edge counter it gates and the
// downstream consumer of its measurement results.
//
// Result handshake: the sequencer (master) raises valid while result and
// overflow hold a completed measurement. It keeps all three stable until it
// samples valid & ready together on a rising eclk edge. Only that edge
// transfers the result. The consumer (slave) may drive ready at any time,
// and ready has no effect while valid is low.
//
// Counter side: the master drives en_counter. The slave side (the counter)
// returns its running count and its 999-reached flag.
interface gate_sequencer_if #(
  parameter int CNT_W = 11
);
  logic             en_counter;
  logic [CNT_W-1:0] cnt;
  logic             cnt_full;
  logic [CNT_W-1:0] result;
  logic             overflow;
  logic             valid;
  logic             ready;

  modport master (
    output en_counter,
    output result,
    output overflow,
    output valid,
    input  cnt,
    input  cnt_full,
    input  ready
  );

  modport slave (
    input  en_counter,
    input  result,
    input  overflow,
    input  valid,
    output cnt,
    output cnt_full,
    output ready
  );
endinterface

// File: rtl/gate_sequencer.sv
// Measurement sequencer for the edge counter.
// On a start request in IDLE it opens the counter gate for exactly GATE_LEN
// eclk cycles. It then spends one CAPTURE cycle latching the counter's final
// value, while the counter still holds that value with the gate closed. The
// captured result and the overflow flag are presented on a valid/ready
// handshake until the consumer accepts them.
// GATE_LEN must lie in 1..2047 so that it fits the 11-bit gate-cycle counter.
module gate_sequencer #(
  parameter int GATE_LEN = 1000,
  parameter int CNT_W    = 11
) (
  input  logic             eclk,
  input  logic             clr,
  input  logic             start,
  output logic             busy,
  output logic [1:0]       dbg_state_o,
  output logic [10:0]      dbg_gate_cnt_o,
  gate_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GATE    = 2'd1,
    S_CAPTURE = 2'd2,
    S_HOLD    = 2'd3
  } state_t;

  // Last value of the gate-cycle counter. The counter starts at 0 in the
  // first gate cycle, so reaching GATE_LEN-1 means GATE_LEN cycles are done.
  localparam logic [10:0] GATE_LAST = 11'(GATE_LEN - 1);

  state_t           state_q;
  state_t           state_d;
  logic [10:0]      gate_cnt_q;
  logic [10:0]      gate_cnt_d;
  logic             en_q;
  logic             en_d;
  logic [CNT_W-1:0] result_q;
  logic [CNT_W-1:0] result_d;
  logic             ovf_q;
  logic             ovf_d;
  logic             valid_c;
  logic             busy_c;

  // These events are decoded from the current state only. They feed both the
  // next-state logic and the datapath.
  logic gate_entry;
  logic gate_done;
  logic hs_done;

  assign gate_entry = (state_q == S_IDLE) && start;
  assign gate_done  = (state_q == S_GATE) && (gate_cnt_q == GATE_LAST);
  assign hs_done    = (state_q == S_HOLD) && bus.ready;

  // State register: reset returns to IDLE immediately, even mid-gate.
  always_ff @(posedge eclk or negedge clr) begin
    if (!clr) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: start is seen only in IDLE and ready only in HOLD.
  // A start arriving in the same HOLD cycle as ready is therefore dropped.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (gate_entry) begin
          state_d = S_GATE;
        end
      end
      S_GATE: begin
        if (gate_done) begin
          state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (hs_done) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output and datapath decode: next values of the registered outputs, plus
  // the flags decoded directly from the state.
  always_comb begin
    valid_c = (state_q == S_HOLD);
    busy_c  = (state_q != S_IDLE);

    // The gate is registered from the next state, so it is high exactly in
    // the cycles where the state register holds GATE.
    en_d = (state_d == S_GATE);

    gate_cnt_d = gate_cnt_q;
    if (gate_entry) begin
      gate_cnt_d = 11'd0;
    end else if (state_q == S_GATE) begin
      gate_cnt_d = gate_cnt_q + 11'd1;
    end

    // The counter still holds its final value during CAPTURE. It clears on
    // the same edge that latches that value here.
    result_d = result_q;
    if (state_q == S_CAPTURE) begin
      result_d = bus.cnt;
    end

    // cnt_full lags the counter by one edge, so it is also watched on the
    // CAPTURE edge. The flag stays sticky until the next gate opens.
    ovf_d = ovf_q;
    if (gate_entry) begin
      ovf_d = 1'b0;
    end else if (((state_q == S_GATE) || (state_q == S_CAPTURE)) && bus.cnt_full) begin
      ovf_d = 1'b1;
    end
  end

  // Registered gate, gate-cycle counter, result and overflow. All of them
  // clear asynchronously on reset.
  always_ff @(posedge eclk or negedge clr) begin
    if (!clr) begin
      en_q       <= 1'b0;
      gate_cnt_q <= 11'd0;
      result_q   <= '0;
      ovf_q      <= 1'b0;
    end else begin
      en_q       <= en_d;
      gate_cnt_q <= gate_cnt_d;
      result_q   <= result_d;
      ovf_q      <= ovf_d;
    end
  end

  assign bus.en_counter = en_q;
  assign bus.result     = result_q;
  assign bus.overflow   = ovf_q;
  assign bus.valid      = valid_c;
  assign busy           = busy_c;

  assign dbg_state_o    = state_q;
  assign dbg_gate_cnt_o = gate_cnt_q;

endmodule
